// File: rtl/revelador_casillas.sv
// Player-side reveal engine for the 8x8 Buscaminas board: handles reveal/flag commands,
// flood-fills zero-adjacency regions through a 64-entry FIFO and tracks game status.
module revelador_casillas (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [2:0]  cmd_fila,
   input  logic [2:0]  cmd_col,
   input  logic [5:0]  cantidad_bombas,
   output logic        rd_en,
   output logic [5:0]  rd_addr,
   input  logic [8:0]  rd_data,
   output logic [63:0] revelada,
   output logic [63:0] bandera,
   output logic [6:0]  num_reveladas,
   output logic [6:0]  num_banderas,
   output logic [1:0]  estado_juego,
   output logic        done
);

   typedef enum logic [2:0] {S_IDLE, S_POP, S_ESPERA, S_VECINOS, S_FIN} state_t;
   typedef enum logic [1:0] {JUGANDO = 2'd0, GANADO = 2'd1, PERDIDO = 2'd2} estado_t;

   state_t      state_q, state_d;
   estado_t     estado_q, estado_d;
   logic [63:0] revelada_q, revelada_d;
   logic [63:0] bandera_q, bandera_d;
   logic [63:0] pendiente_q, pendiente_d;
   logic [6:0]  num_rev_q, num_rev_d;
   logic [6:0]  num_ban_q, num_ban_d;
   logic [5:0]  cell_q, cell_d;
   logic [2:0]  nb_q, nb_d;

   logic [5:0]  fifo_mem [64];
   logic [5:0]  wr_ptr_q, rd_ptr_q;
   logic [6:0]  cnt_q;
   logic        push, pop, flush;
   logic [5:0]  push_idx;
   logic [5:0]  fifo_head;

   logic [3:0]  nb_dr, nb_dc, nb_fila, nb_col;
   logic        nb_ok;
   logic [5:0]  nb_idx;
   logic [5:0]  cmd_idx;
   logic [3:0]  unused_rd_bits;

   assign unused_rd_bits = rd_data[7:4];
   assign fifo_head      = fifo_mem[rd_ptr_q];
   assign cmd_idx        = {cmd_fila, cmd_col};

   assign cmd_ready     = (state_q == S_IDLE);
   assign rd_en         = (state_q == S_POP);
   assign rd_addr       = (state_q == S_POP) ? fifo_head : 6'd0;
   assign done          = (state_q == S_FIN);
   assign revelada      = revelada_q;
   assign bandera       = bandera_q;
   assign num_reveladas = num_rev_q;
   assign num_banderas  = num_ban_q;
   assign estado_juego  = estado_q;

   // Neighbour offsets in fixed scan order; a row/col of -1 or 8 sets bit 3 and marks out of bounds.
   always_comb begin
      nb_dr = 4'd0;
      nb_dc = 4'd0;
      case (nb_q)
         3'd0: begin nb_dr = 4'hF; nb_dc = 4'hF; end
         3'd1: begin nb_dr = 4'hF; nb_dc = 4'h0; end
         3'd2: begin nb_dr = 4'hF; nb_dc = 4'h1; end
         3'd3: begin nb_dr = 4'h0; nb_dc = 4'hF; end
         3'd4: begin nb_dr = 4'h0; nb_dc = 4'h1; end
         3'd5: begin nb_dr = 4'h1; nb_dc = 4'hF; end
         3'd6: begin nb_dr = 4'h1; nb_dc = 4'h0; end
         default: begin nb_dr = 4'h1; nb_dc = 4'h1; end
      endcase
      nb_fila = {1'b0, cell_q[5:3]} + nb_dr;
      nb_col  = {1'b0, cell_q[2:0]} + nb_dc;
      nb_ok   = !nb_fila[3] && !nb_col[3];
      nb_idx  = {nb_fila[2:0], nb_col[2:0]};
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d     = state_q;
      estado_d    = estado_q;
      revelada_d  = revelada_q;
      bandera_d   = bandera_q;
      pendiente_d = pendiente_q;
      num_rev_d   = num_rev_q;
      num_ban_d   = num_ban_q;
      cell_d      = cell_q;
      nb_d        = nb_q;
      push        = 1'b0;
      push_idx    = 6'd0;
      pop         = 1'b0;
      flush       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_FIN;
               if (estado_q == JUGANDO) begin
                  if (cmd_op) begin
                     if (!revelada_q[cmd_idx]) begin
                        bandera_d[cmd_idx] = !bandera_q[cmd_idx];
                        num_ban_d = bandera_q[cmd_idx] ? num_ban_q - 7'd1 : num_ban_q + 7'd1;
                     end
                  end else if (!bandera_q[cmd_idx] && !revelada_q[cmd_idx]) begin
                     push                 = 1'b1;
                     push_idx             = cmd_idx;
                     pendiente_d[cmd_idx] = 1'b1;
                     state_d              = S_POP;
                  end
               end
            end
         end
         S_POP: begin
            pop     = 1'b1;
            cell_d  = fifo_head;
            state_d = S_ESPERA;
         end
         S_ESPERA: begin
            revelada_d[cell_q]  = 1'b1;
            pendiente_d[cell_q] = 1'b0;
            num_rev_d           = num_rev_q + 7'd1;
            if (rd_data[8]) begin
               estado_d    = PERDIDO;
               flush       = 1'b1;
               pendiente_d = '0;
               state_d     = S_FIN;
            end else if (rd_data[3:0] == 4'd0) begin
               nb_d    = 3'd0;
               state_d = S_VECINOS;
            end else begin
               state_d = (cnt_q != 7'd0) ? S_POP : S_FIN;
            end
         end
         S_VECINOS: begin
            if (nb_ok && !revelada_q[nb_idx] && !bandera_q[nb_idx] && !pendiente_q[nb_idx]) begin
               push                = 1'b1;
               push_idx            = nb_idx;
               pendiente_d[nb_idx] = 1'b1;
            end
            nb_d = nb_q + 3'd1;
            if (nb_q == 3'd7) begin
               state_d = ((cnt_q != 7'd0) || push) ? S_POP : S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Win is resolved on entry to FIN so estado_juego is already final while done is high.
      if ((state_d == S_FIN) && (estado_d == JUGANDO) &&
          (num_rev_d == (7'd64 - {1'b0, cantidad_bombas}))) begin
         estado_d = GANADO;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         estado_q    <= JUGANDO;
         revelada_q  <= '0;
         bandera_q   <= '0;
         pendiente_q <= '0;
         num_rev_q   <= '0;
         num_ban_q   <= '0;
         cell_q      <= '0;
         nb_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         estado_q    <= estado_d;
         revelada_q  <= revelada_d;
         bandera_q   <= bandera_d;
         pendiente_q <= pendiente_d;
         num_rev_q   <= num_rev_d;
         num_ban_q   <= num_ban_d;
         cell_q      <= cell_d;
         nb_q        <= nb_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 6'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 6'd1;
            if (push && !pop)      cnt_q <= cnt_q + 7'd1;
            else if (pop && !push) cnt_q <= cnt_q - 7'd1;
         end
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and count define emptiness, so stale words are never read.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= push_idx;
   end

endmodule

// File: tb/tb_revelador_casillas.sv
// Directed self-checking bench for revelador_casillas with a 1-cycle-latency board memory model.
module tb_revelador_casillas;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_op = 1'b0;
   logic [2:0]  cmd_fila = 3'd0;
   logic [2:0]  cmd_col = 3'd0;
   logic [5:0]  cantidad_bombas = 6'd0;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [8:0]  rd_data = 9'd0;
   logic [63:0] revelada, bandera;
   logic [6:0]  num_reveladas, num_banderas;
   logic [1:0]  estado_juego;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [8:0] board [64];
   int         read_cnt [64];
   int         total_reads = 0;
   int         snap [64];

   revelador_casillas dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_fila(cmd_fila), .cmd_col(cmd_col), .cantidad_bombas(cantidad_bombas),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .revelada(revelada),
      .bandera(bandera), .num_reveladas(num_reveladas), .num_banderas(num_banderas),
      .estado_juego(estado_juego), .done(done)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 64; i++) read_cnt[i] = 0;

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data           <= board[rd_addr];
         read_cnt[rd_addr] <= read_cnt[rd_addr] + 1;
         total_reads       <= total_reads + 1;
      end
   end

   task automatic set_bombs(input logic [63:0] m);
      for (int f = 0; f < 8; f++) begin
         for (int c = 0; c < 8; c++) begin
            int n;
            n = 0;
            for (int df = -1; df <= 1; df++)
               for (int dc = -1; dc <= 1; dc++)
                  if (!(df == 0 && dc == 0) && f + df >= 0 && f + df < 8 && c + dc >= 0 && c + dc < 8)
                     if (m[(f + df) * 8 + c + dc]) n++;
            board[f * 8 + c] = {m[f * 8 + c], 4'd0, n[3:0]};
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic take_snap();
      for (int i = 0; i < 64; i++) snap[i] = read_cnt[i];
   endtask

   task automatic do_cmd(input logic op, input logic [2:0] f, input logic [2:0] c,
                         output int lat, output logic rd_en1, output logic [5:0] addr1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_fila = f; cmd_col = c;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1; rd_en1 = rd_en; addr1 = rd_addr;
      while (!done && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL cmd_timeout no done within %0d cycles", lat); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
      checks++; if (revelada !== 64'd0 || bandera !== 64'd0) begin errors++; $display("FAIL rst_bitmaps rev=%h flag=%h exp=0", revelada, bandera); end
      checks++; if (num_reveladas !== 7'd0 || num_banderas !== 7'd0) begin errors++; $display("FAIL rst_counts rev=%0d flag=%0d exp=0", num_reveladas, num_banderas); end
      checks++; if (estado_juego !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL rst_status estado=%0d done=%b exp=0/0", estado_juego, done); end
      checks++; if (rd_en !== 1'b0 || rd_addr !== 6'd0) begin errors++; $display("FAIL rst_read rd_en=%b rd_addr=%0d exp=0/0", rd_en, rd_addr); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_flag();
      int lat; logic r1; logic [5:0] a1;
      set_bombs(64'd0); cantidad_bombas = 6'd10;
      apply_reset();
      do_cmd(1'b1, 3'd3, 3'd4, lat, r1, a1);
      checks++; if (lat !== 1) begin errors++; $display("FAIL flag_latency got=%0d exp=1", lat); end
      checks++; if (bandera[28] !== 1'b1 || num_banderas !== 7'd1) begin errors++; $display("FAIL flag_set bit=%b count=%0d exp=1/1", bandera[28], num_banderas); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL flag_done_pulse done=%b ready=%b exp=0/1", done, cmd_ready); end
      do_cmd(1'b1, 3'd3, 3'd4, lat, r1, a1);
      checks++; if (bandera !== 64'd0 || num_banderas !== 7'd0) begin errors++; $display("FAIL flag_clear map=%h count=%0d exp=0/0", bandera, num_banderas); end
      checks++; if (estado_juego !== 2'd0 || num_reveladas !== 7'd0) begin errors++; $display("FAIL flag_status estado=%0d rev=%0d exp=0/0", estado_juego, num_reveladas); end
   endtask

   task automatic test_reveal_nonzero();
      int lat; logic r1; logic [5:0] a1;
      set_bombs(64'h0000_0000_0000_0102); cantidad_bombas = 6'd2;
      apply_reset();
      do_cmd(1'b0, 3'd0, 3'd0, lat, r1, a1);
      checks++; if (r1 !== 1'b1 || a1 !== 6'd0) begin errors++; $display("FAIL reveal_read_t1 rd_en=%b addr=%0d exp=1/0", r1, a1); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL reveal_latency got=%0d exp=3", lat); end
      checks++; if (revelada !== 64'h1 || num_reveladas !== 7'd1) begin errors++; $display("FAIL reveal_result map=%h count=%0d exp=1/1", revelada, num_reveladas); end
      do_cmd(1'b0, 3'd0, 3'd0, lat, r1, a1);
      checks++; if (lat !== 1 || num_reveladas !== 7'd1) begin errors++; $display("FAIL reveal_again lat=%0d count=%0d exp=1/1", lat, num_reveladas); end
      do_cmd(1'b1, 3'd0, 3'd0, lat, r1, a1);
      checks++; if (bandera !== 64'd0 || num_banderas !== 7'd0) begin errors++; $display("FAIL flag_revealed map=%h count=%0d exp=0/0", bandera, num_banderas); end
   endtask

   task automatic test_flood_all();
      int lat; logic r1; logic [5:0] a1; int bad; int reads0;
      set_bombs(64'd0); cantidad_bombas = 6'd0;
      apply_reset();
      take_snap(); reads0 = total_reads;
      do_cmd(1'b0, 3'd4, 3'd4, lat, r1, a1);
      checks++; if (lat !== 641) begin errors++; $display("FAIL flood_latency got=%0d exp=641", lat); end
      checks++; if (revelada !== {64{1'b1}} || num_reveladas !== 7'd64) begin errors++; $display("FAIL flood_all map=%h count=%0d exp=all/64", revelada, num_reveladas); end
      @(negedge clk);
      checks++; if (estado_juego !== 2'd1) begin errors++; $display("FAIL flood_win estado=%0d exp=1", estado_juego); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (read_cnt[i] - snap[i] != 1) bad++;
      checks++; if (bad !== 0 || total_reads - reads0 !== 64) begin errors++; $display("FAIL flood_reads bad_cells=%0d reads=%0d exp=0/64", bad, total_reads - reads0); end
   endtask

   task automatic test_bomb();
      int lat; logic r1; logic [5:0] a1; int reads0;
      set_bombs(64'h8000_0000_0000_0000); cantidad_bombas = 6'd1;
      apply_reset();
      do_cmd(1'b0, 3'd7, 3'd7, lat, r1, a1);
      checks++; if (lat !== 3 || estado_juego !== 2'd2) begin errors++; $display("FAIL bomb_lost lat=%0d estado=%0d exp=3/2", lat, estado_juego); end
      checks++; if (revelada !== 64'h8000_0000_0000_0000 || num_reveladas !== 7'd1) begin errors++; $display("FAIL bomb_map map=%h count=%0d exp=bit63/1", revelada, num_reveladas); end
      reads0 = total_reads;
      do_cmd(1'b0, 3'd0, 3'd0, lat, r1, a1);
      checks++; if (lat !== 1 || num_reveladas !== 7'd1 || total_reads !== reads0) begin errors++; $display("FAIL lost_reveal lat=%0d count=%0d reads=%0d exp=1/1/0", lat, num_reveladas, total_reads - reads0); end
      do_cmd(1'b1, 3'd0, 3'd0, lat, r1, a1);
      checks++; if (lat !== 1 || bandera !== 64'd0 || estado_juego !== 2'd2) begin errors++; $display("FAIL lost_flag lat=%0d map=%h estado=%0d exp=1/0/2", lat, bandera, estado_juego); end
   endtask

   task automatic test_flag_blocks();
      int lat; logic r1; logic [5:0] a1;
      set_bombs(64'h1); cantidad_bombas = 6'd1;
      apply_reset();
      do_cmd(1'b1, 3'd0, 3'd1, lat, r1, a1);
      do_cmd(1'b0, 3'd7, 3'd7, lat, r1, a1);
      checks++; if (lat !== 605) begin errors++; $display("FAIL block_latency got=%0d exp=605", lat); end
      checks++; if (revelada !== 64'hFFFF_FFFF_FFFF_FFFC || num_reveladas !== 7'd62) begin errors++; $display("FAIL block_map map=%h count=%0d exp=..FFFC/62", revelada, num_reveladas); end
      @(negedge clk);
      checks++; if (estado_juego !== 2'd0) begin errors++; $display("FAIL block_status estado=%0d exp=0", estado_juego); end
      do_cmd(1'b1, 3'd0, 3'd1, lat, r1, a1);
      checks++; if (bandera !== 64'd0 || num_banderas !== 7'd0) begin errors++; $display("FAIL unflag map=%h count=%0d exp=0/0", bandera, num_banderas); end
      do_cmd(1'b0, 3'd0, 3'd1, lat, r1, a1);
      checks++; if (lat !== 3 || num_reveladas !== 7'd63) begin errors++; $display("FAIL last_reveal lat=%0d count=%0d exp=3/63", lat, num_reveladas); end
      @(negedge clk);
      checks++; if (estado_juego !== 2'd1 || revelada[0] !== 1'b0) begin errors++; $display("FAIL last_win estado=%0d bit0=%b exp=1/0", estado_juego, revelada[0]); end
   endtask

   task automatic test_reset_mid_flood();
      int reads0;
      set_bombs(64'd0); cantidad_bombas = 6'd0;
      apply_reset();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_fila = 3'd4; cmd_col = 3'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (revelada[36] !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midflood_progress bit36=%b done=%b exp=1/0", revelada[36], done); end
      rst = 1'b1;
      #1;
      checks++; if (revelada !== 64'd0 || num_reveladas !== 7'd0 || estado_juego !== 2'd0) begin errors++; $display("FAIL midflood_rst map=%h count=%0d estado=%0d exp=0", revelada, num_reveladas, estado_juego); end
      checks++; if (cmd_ready !== 1'b1 || rd_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midflood_ctrl ready=%b rd_en=%b done=%b exp=1/0/0", cmd_ready, rd_en, done); end
      reads0 = total_reads;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (total_reads !== reads0 || cmd_ready !== 1'b1 || revelada !== 64'd0) begin errors++; $display("FAIL post_rst reads=%0d ready=%b map=%h exp=0/1/0", total_reads - reads0, cmd_ready, revelada); end
   endtask

   initial begin
      test_reset();
      test_flag();
      test_reveal_nonzero();
      test_flood_all();
      test_bomb();
      test_flag_blocks();
      test_reset_mid_flood();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/revelador_casillas.md
# revelador_casillas

Player-side reveal engine for the 8x8 Buscaminas board: the reader counterpart to the bomb-placement/adjacency writer. It accepts reveal and flag commands over a valid/ready handshake and reads cell words from the board memory through a 1-cycle-latency read port. It flood-fills zero-adjacency regions with an internal 64-entry FIFO and maintains the revealed/flag bitmaps, counters and game status consumed by the VGA and seven-segment paths.

## Interface
- No parameters; the board is fixed at 8x8 (64 cells, index = {fila, col}).
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = reveal, 1 = toggle flag
- cmd_fila  in  3  row of target cell
- cmd_col  in  3  column of target cell
- cantidad_bombas  in  6  bombs placed; stable while a game is running
- rd_en  out  1  board read strobe
- rd_addr  out  6  board read index {fila, col}
- rd_data  in  9  cell word, valid the cycle after rd_en; bit 8 = bomb, bits 3:0 = adjacent bombs (0-8)
- revelada  out  64  revealed bitmap
- bandera  out  64  flag bitmap
- num_reveladas  out  7  count of revealed cells
- num_banderas  out  7  count of flags
- estado_juego  out  2  0 = jugando, 1 = ganado, 2 = perdido
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, POP, ESPERA, VECINOS, FIN.
- IDLE: cmd_ready=1. On cmd_valid, the command is accepted. Action depends on the case:
  - estado_juego != jugando: the command has no effect; go to FIN.
  - Flag op: toggle bandera[c] only if revelada[c]=0, and update num_banderas by ±1; go to FIN.
  - Reveal op on a flagged or revealed cell: no effect; go to FIN.
  - Reveal op otherwise: push c to the FIFO, set pendiente[c], go to POP.
- POP: rd_en=1, rd_addr=FIFO head; pop; go to ESPERA.
- ESPERA: sample rd_data and apply the result:
  - Set revelada[c], clear pendiente[c], increment num_reveladas.
  - If the bomb bit is set: estado_juego=perdido, flush the FIFO, clear all pendiente, go to FIN.
  - If count==0: go to VECINOS.
  - Otherwise: go to POP if the FIFO is non-empty, else FIN.
- VECINOS: iterate the 8 neighbours in fixed order (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1), one per cycle (8 cycles).
  - Push a neighbour only if it is in bounds and its revelada, bandera and pendiente bits are all 0; set its pendiente bit when pushed.
  - Out-of-bounds neighbours still consume their cycle.
  - After the 8th neighbour: go to POP if the FIFO is non-empty, else FIN.
- FIN: done=1 for one cycle.
  - If estado_juego=jugando and num_reveladas == 64 − cantidad_bombas, set estado_juego=ganado.
  - Go to IDLE.
- FIFO: depth 64. The pendiente/revelada checks guarantee each cell is enqueued at most once per game, so overflow cannot occur. A push and a pop never happen in the same cycle.
- Flags block flood-fill. Flagged neighbours are neither revealed nor counted.

## Timing
- Reset (async, immediate) sets:
  - state=IDLE, cmd_ready=1;
  - all bitmaps and pendiente = 0, FIFO empty;
  - num_reveladas = num_banderas = 0, estado_juego=0;
  - rd_en=0, rd_addr=0, done=0.
- Reset mid-flood aborts the operation with no further reads.
- Accept cycle T0:
  - Flag or no-effect command: done at T1, cmd_ready high again at T2.
  - Reveal of a nonzero safe cell: rd_en at T1, sampling at T2, done at T3.
  - Reveal of a zero cell that adds no neighbours: done at T11.
- Per-cell cost in a flood: 2 cycles (POP, ESPERA), plus 8 cycles if the cell is a zero cell.
- Outputs (revelada, counters, estado_juego) update on the ESPERA/FIN edge. They are stable while done is high.
- cmd_* inputs are ignored outside IDLE.

## Test plan
- Reset, then flag (3,4) twice → bandera[28] goes 1 then 0; num_banderas 1 then 0; done 1 cycle after each accept; estado_juego=0.
- Board with adjacency count 2 at (0,0), reveal (0,0) → rd_en/rd_addr=0 at T1; revelada[0]=1 and num_reveladas=1 at T3 together with done; a second reveal of the same cell leaves num_reveladas=1.
- cantidad_bombas=0, all counts 0, reveal (4,4) → all 64 cells revealed; num_reveladas=64; estado_juego=ganado; no cell read twice.
- Bomb at (7,7), reveal (7,7) → estado_juego=perdido at done; later reveals and flags are accepted with no effect.
- Single bomb at (0,0) with (0,1) flagged, reveal (7,7) → flood stops at the flag and does not reveal (0,0) or (0,1); estado_juego stays jugando; unflagging then revealing (0,1) → num_reveladas=63 and estado_juego=ganado.
- Assert rst during VECINOS of a flood → all outputs return to reset values immediately; cmd_ready=1 after release.
